// File: rtl/ternary_popcount_sched.sv
`default_nettype none
// ============================================================================
// Module   : ternary_popcount_sched
// Brief    : Time-multiplexes one shared 20-input popcount unit across a wide
//            ternary-neuron input vector. Positive-weight matches are counted
//            first, then negative-weight matches. The block then produces a
//            signed sum and a thresholded activation.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_popcount_sched #(
    parameter int CHUNKS = 4,
    parameter int ACC_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [20*CHUNKS-1:0]     in_x,
    input  logic [20*CHUNKS-1:0]     in_wpos,
    input  logic [20*CHUNKS-1:0]     in_wneg,
    input  logic signed [ACC_W:0]    in_thr,
    output logic [19:0]              pc_a,
    input  logic [4:0]               pc_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W:0]    out_sum,
    output logic                     out_act,
    output logic                     busy
);

    localparam int              C_KW      = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int              C_SUM_W   = ACC_W + 6;
    localparam logic [ACC_W-1:0] C_ACC_MAX = {ACC_W{1'b1}};
    localparam logic [C_KW-1:0]  C_K_LAST  = C_KW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POS  = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [C_KW-1:0]         k_q, k_d;
    logic [20*CHUNKS-1:0]    x_q, x_d;
    logic [20*CHUNKS-1:0]    wpos_q, wpos_d;
    logic [20*CHUNKS-1:0]    wneg_q, wneg_d;
    logic signed [ACC_W:0]   thr_q, thr_d;
    logic [ACC_W-1:0]        acc_pos_q, acc_pos_d;
    logic [ACC_W-1:0]        acc_neg_q, acc_neg_d;
    logic signed [ACC_W:0]   out_sum_q, out_sum_d;
    logic                    out_act_q, out_act_d;

    logic [19:0]             w_x_chunk;
    logic [19:0]             w_wpos_chunk;
    logic [19:0]             w_wneg_chunk;
    logic signed [ACC_W:0]   w_diff;

    // Accumulate one popcount result, clamping at the accumulator maximum.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [4:0]       b);
        logic [C_SUM_W-1:0] s;
        s = C_SUM_W'(a) + C_SUM_W'(b);
        if (s > C_SUM_W'(C_ACC_MAX)) begin
            return C_ACC_MAX;
        end
        return s[ACC_W-1:0];
    endfunction

    // Select chunk k of the latched operands.
    always_comb begin
        w_x_chunk    = '0;
        w_wpos_chunk = '0;
        w_wneg_chunk = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            if (k_q == C_KW'(i)) begin
                w_x_chunk    = x_q[20*i +: 20];
                w_wpos_chunk = wpos_q[20*i +: 20];
                w_wneg_chunk = wneg_q[20*i +: 20];
            end
        end
    end

    // Next-state, datapath updates and outputs of the sequencer.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        wpos_d    = wpos_q;
        wneg_d    = wneg_q;
        thr_d     = thr_q;
        acc_pos_d = acc_pos_q;
        acc_neg_d = acc_neg_q;
        out_sum_d = out_sum_q;
        out_act_d = out_act_q;
        pc_a      = '0;
        w_diff    = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d       = in_x;
                    wpos_d    = in_wpos;
                    wneg_d    = in_wneg;
                    thr_d     = in_thr;
                    acc_pos_d = '0;
                    acc_neg_d = '0;
                    k_d       = '0;
                    state_d   = S_POS;
                end
            end
            S_POS: begin
                pc_a      = w_x_chunk & w_wpos_chunk;
                acc_pos_d = sat_add(acc_pos_q, pc_cnt);
                if (k_q == C_K_LAST) begin
                    k_d     = '0;
                    state_d = S_NEG;
                end else begin
                    k_d = k_q + C_KW'(1);
                end
            end
            S_NEG: begin
                pc_a      = w_x_chunk & w_wneg_chunk;
                acc_neg_d = sat_add(acc_neg_q, pc_cnt);
                if (k_q == C_K_LAST) begin
                    k_d       = '0;
                    // The result is registered from the final negative count
                    // so it is stable for the whole DONE phase.
                    w_diff    = $signed({1'b0, acc_pos_q}) - $signed({1'b0, acc_neg_d});
                    out_sum_d = w_diff;
                    out_act_d = (w_diff >= thr_q);
                    state_d   = S_DONE;
                end else begin
                    k_d = k_q + C_KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operands, counters, accumulators and results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q       <= '0;
            x_q       <= '0;
            wpos_q    <= '0;
            wneg_q    <= '0;
            thr_q     <= '0;
            acc_pos_q <= '0;
            acc_neg_q <= '0;
            out_sum_q <= '0;
            out_act_q <= 1'b0;
        end else begin
            k_q       <= k_d;
            x_q       <= x_d;
            wpos_q    <= wpos_d;
            wneg_q    <= wneg_d;
            thr_q     <= thr_d;
            acc_pos_q <= acc_pos_d;
            acc_neg_q <= acc_neg_d;
            out_sum_q <= out_sum_d;
            out_act_q <= out_act_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = out_sum_q;
    assign out_act   = out_act_q;

endmodule
`default_nettype wire

// File: tb/tb_ternary_popcount_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_popcount_sched
// Brief    : Self-checking bench for ternary_popcount_sched with an exact
//            popcount unit, plus a narrow-accumulator instance whose popcount
//            result is forced to 31 to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_popcount_sched;

    localparam int CHUNKS = 4;
    localparam int ACC_W  = 8;
    localparam int SAT_W  = 6;
    localparam logic [79:0] ALL1 = {80{1'b1}};

    logic               clk = 1'b0;
    logic               rst;

    logic               in_valid, in_ready, out_valid, out_ready, out_act, busy;
    logic [79:0]        in_x, in_wpos, in_wneg;
    logic signed [8:0]  in_thr;
    logic [19:0]        pc_a;
    logic [4:0]         pc_cnt;
    logic signed [8:0]  out_sum;

    logic               s_in_valid, s_in_ready, s_out_valid, s_out_act, s_busy;
    logic [79:0]        s_in_x, s_in_wpos, s_in_wneg;
    logic signed [6:0]  s_in_thr;
    logic [19:0]        s_pc_a;
    logic [4:0]         s_pc_cnt;
    logic signed [6:0]  s_out_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Exact shared popcount unit for the main instance.
    assign pc_cnt   = 5'($countones(pc_a));
    // Forced unit: reports 31 whenever it is driven with a nonzero operand.
    assign s_pc_cnt = (s_pc_a != 20'd0) ? 5'd31 : 5'd0;

    ternary_popcount_sched #(.CHUNKS(CHUNKS), .ACC_W(ACC_W)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_thr(in_thr),
        .pc_a(pc_a), .pc_cnt(pc_cnt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act), .busy(busy)
    );

    ternary_popcount_sched #(.CHUNKS(CHUNKS), .ACC_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_x(s_in_x), .in_wpos(s_in_wpos), .in_wneg(s_in_wneg), .in_thr(s_in_thr),
        .pc_a(s_pc_a), .pc_cnt(s_pc_cnt),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_sum(s_out_sum), .out_act(s_out_act), .busy(s_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] chunk(input logic [79:0] v, input int k);
        return v[20*k +: 20];
    endfunction

    // Reference: saturating per-pass totals, signed difference.
    function automatic int model_sum(input logic [79:0] x, input logic [79:0] wp,
                                     input logic [79:0] wn, input int accw,
                                     input bit force31);
        int ap = 0;
        int an = 0;
        int mx = (1 << accw) - 1;
        int c;
        for (int k = 0; k < CHUNKS; k++) begin
            c  = force31 ? ((chunk(x & wp, k) != 0) ? 31 : 0) : $countones(chunk(x & wp, k));
            ap = (ap + c > mx) ? mx : ap + c;
            c  = force31 ? ((chunk(x & wn, k) != 0) ? 31 : 0) : $countones(chunk(x & wn, k));
            an = (an + c > mx) ? mx : an + c;
        end
        return ap - an;
    endfunction

    // Called one sample after the accept edge; follows the operation to DONE.
    task automatic wait_result(input logic [79:0] x, input logic [79:0] wp,
                               input logic [79:0] wn, input int thr);
        logic [19:0] seen[$];
        logic [19:0] exp_a;
        logic [8:0]  e9;
        int          lat = 0;
        int          nbad = 0;
        int          s;
        while (!out_valid && lat < 40) begin
            seen.push_back(pc_a);
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(2 * CHUNKS));
        for (int i = 0; i < 2 * CHUNKS; i++) begin
            exp_a = (i < CHUNKS) ? chunk(x & wp, i) : chunk(x & wn, i - CHUNKS);
            if (i >= seen.size() || seen[i] !== exp_a) nbad++;
        end
        chk("pc_seq", 64'(nbad), 64'd0);
        s  = model_sum(x, wp, wn, ACC_W, 1'b0);
        e9 = 9'(s);
        chk("sum", {55'd0, out_sum}, {55'd0, e9});
        chk("act", 64'(out_act), 64'(s >= thr));
        chk("pc_a_done", 64'(pc_a), 64'd0);
    endtask

    task automatic do_vec(input logic [79:0] x, input logic [79:0] wp,
                          input logic [79:0] wn, input int thr);
        in_x     = x;
        in_wpos  = wp;
        in_wneg  = wn;
        in_thr   = 9'(thr);
        in_valid = 1'b1;
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("pc_a_idle", 64'(pc_a), 64'd0);
        step();
        in_valid = 1'b0;
        in_x     = ~x;
        in_wpos  = ~wp;
        in_thr   = 9'(~thr);
        chk("busy_ready", {62'd0, busy, in_ready}, 64'd2);
        wait_result(x, wp, wn, thr);
        out_ready = 1'b1;
        step();
    endtask

    initial begin
        logic [95:0]       r0, r1, r2;
        logic [79:0]       bx, bp, bn;
        logic signed [8:0] held;
        int                thr, lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_wpos = '0; in_wneg = '0; in_thr = '0;
        s_in_valid = 1'b0; s_in_x = '0; s_in_wpos = '0; s_in_wneg = '0; s_in_thr = '0;
        #12;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", {55'd0, out_sum}, 64'd0);
        chk("rst_act", 64'(out_act), 64'd0);
        chk("rst_pc_a", 64'(pc_a), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Directed cases
        do_vec(ALL1, ALL1, '0, 40);
        chk("sum80", {55'd0, out_sum}, 64'd80);
        do_vec(ALL1, 80'hFFFFF, ~80'hFFFFF, -41);
        do_vec(ALL1, 80'hFFFFF, ~80'hFFFFF, -39);
        do_vec(80'h0000F000F000F000F000, ALL1, ALL1, 0);

        // Randomized vectors
        for (int n = 0; n < 20; n++) begin
            r0 = {$urandom(), $urandom(), $urandom()};
            r1 = {$urandom(), $urandom(), $urandom()};
            r2 = {$urandom(), $urandom(), $urandom()};
            if (n % 3 == 0) r1 = r1 & ~r2;
            thr = int'($urandom_range(0, 511)) - 256;
            if (n % 4 == 1) thr = int'($urandom_range(0, 40)) - 20;
            do_vec(r0[79:0], r1[79:0], r2[79:0], thr);
        end

        // Backpressure: result held while new data waits for IDLE
        out_ready = 1'b0;
        in_x = ALL1; in_wpos = ALL1; in_wneg = 80'hFF; in_thr = 9'sd50; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_result(ALL1, ALL1, 80'hFF, 50);
        held = out_sum;
        bx = 80'h123456789ABCDEF01234; bp = 80'hF0F0F0F0F0F0F0F0F0F0; bn = 80'h0F0F0F0F0F0F0F0F0F0F;
        in_x = bx; in_wpos = bp; in_wneg = bn; in_thr = -9'sd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold", {53'd0, out_valid, in_ready, out_sum}, {53'd0, 1'b1, 1'b0, held});
        end
        out_ready = 1'b1;
        step();
        chk("bp_release", {61'd0, busy, in_ready, out_valid}, 64'd2);
        step();
        in_valid = 1'b0;
        chk("bp_accept", 64'(busy), 64'd1);
        wait_result(bx, bp, bn, -3);
        step();

        // Reset during the second NEG cycle
        bx = 80'hFEDCBA9876543210FEDC;
        in_x = bx; in_wpos = ALL1; in_wneg = ALL1; in_thr = 9'sd0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("neg2_pc_a", 64'(pc_a), 64'(chunk(bx, 1)));
        #2 rst = 1'b1;
        #1;
        chk("abort", {60'd0, out_valid, in_ready, busy, (pc_a != 20'd0)}, 64'h4);
        #1 rst = 1'b0;
        step();
        r0 = {$urandom(), $urandom(), $urandom()};
        do_vec(r0[79:0], ~r0[79:0] | 80'hFFFF, r0[79:0] >> 7, 5);

        // Saturation on the narrow instance
        s_in_x = ALL1; s_in_wpos = ALL1; s_in_wneg = '0; s_in_thr = 7'sd0; s_in_valid = 1'b1;
        step();
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("sat_latency", 64'(lat), 64'd8);
        chk("sat_sum", {57'd0, s_out_sum}, 64'(7'(model_sum(ALL1, ALL1, '0, SAT_W, 1'b1))));
        chk("sat_63", {57'd0, s_out_sum}, 64'd63);
        chk("sat_act", 64'(s_out_act), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
